ibex_mult_pext_seq: RTL and testbench
=====================================

Name: ibex_mult_pext_seq

Overview:
Parametrised, multi-cycle SIMD multiply/MAC sequencer for the P-extension datapath.
- Accepts one op per handshake in any multiplier mode (M8x8, M16x16, M32x16, M32x32).
- Issues partial products over NumMul 17x17 signed multiplier slots per cycle, accumulates them, then applies combine, accumulate, round and saturate.
- Sits between the decoder and the ALU writeback mux, alongside the existing multiplier-mode decode logic.
- Iteration count scales with NumMul, replacing fixed per-instruction cycle counts.

Parameters:
NumMul, 2, number of 17x17 signed multiplier slots used per cycle; legal values 1, 2, 4.
SatEn, 1, 1 implements 32-bit signed saturation; 0 ignores sat_i and ties ov_o to 0.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
valid_i  input  1  op request
ready_o  output  1  op accepted when valid_i && ready_o
kill_i  input  1  abort the op in flight; return to IDLE next cycle
mode_i  input  ibex_pkg_pext::mult_pext_mode_e  multiplier mode
add_mode_i  input  2  bit0: combine p1 with p0; bit1: add op_c_i
sub_i  input  2  bit0: p1-p0 instead of p1+p0; bit1: c-sum instead of c+sum
signed_a_i  input  1  op_a_i elements are signed
signed_b_i  input  1  op_b_i elements are signed
swap_i  input  1  M16x16 cross pairing
bsel_i  input  1  M32x16 b half select (1 = top)
high_i  input  1  M32x32 return product bits [63:32]
round_i  input  1  round-half-up on the discarded MSB
sat_i  input  1  saturate the final result
op_a_i  input  32  operand a
op_b_i  input  32  operand b
op_c_i  input  32  accumulator operand (rd)
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
result_o  output  32  result
ov_o  output  1  saturation occurred
busy_o  output  1  state != IDLE

Behaviour:
Reset values:
- State IDLE. ready_o=1, valid_o=0, busy_o=0, result_o=0, ov_o=0. Slot counter and 66-bit accumulator cleared.

Capture:
- On accept, latch all operands and controls. The accumulator clears and the slot counter loads 0.

Slot count S per mode and slot lists:
- M8x8: S=4. Products a.byte[i]*b.byte[i], i=0..3.
- M16x16: S=2. p0 = a[15:0]*b[15:0]; p1 = a[31:16]*b[31:16]. With swap_i: p0 = a[15:0]*b[31:16]; p1 = a[31:16]*b[15:0].
- M32x16: S=2. Multiply by h = bsel_i ? b[31:16] : b[15:0]. Slots a_lo*h (shift 0) and a_hi*h (shift 16).
- M32x32: S=4. Slot order a_lo*b_lo (shift 0), a_hi*b_lo (16), a_lo*b_hi (16), a_hi*b_hi (32).

Operand extension:
- Low 16-bit halves of 32-bit operands are zero-extended to 17 bits.
- Top halves and all 8/16-bit elements are extended per signed_a_i / signed_b_i.

State machine:
- MUL: each cycle processes min(NumMul, S - count) slots and advances the count. Leaves MUL after ceil(S/NumMul) cycles.
- FIN (one cycle): compute r, then move to DONE.
  - M8x8: sum = sum of 4 products.
  - M16x16: r = add_mode_i[0] ? (p1 ± p0) : p0.
  - M32x16: r = P[47:16] + (round_i & P[15]).
  - M32x32: r = high_i ? P[63:32] + (round_i & P[31]) : P[31:0].
  - If add_mode_i[1]: r = c ± r, with sub_i[1] selecting minus.
  - All intermediate arithmetic is signed 66-bit.
  - If sat_i && SatEn: clamp r to [0x8000_0000, 0x7FFF_FFFF] and set ov_o on clamp. Otherwise take r[31:0] and ov_o=0.
  - Register result_o and ov_o.
- DONE: valid_o=1. result_o and ov_o stay stable until ready_i; then go to IDLE.
- ready_o=1 only in IDLE, so there is no accept in the same cycle as a result handoff.

Latency:
- Accept to valid_o = ceil(S/NumMul) + 1 cycles.
- Examples: NumMul=2 gives M16x16 2 cycles, M32x32 3 cycles. NumMul=1 gives M32x32 5 cycles.

kill_i:
- In MUL or FIN: next state is IDLE, valid_o stays 0, no result is produced.
- In DONE: drops the result and goes to IDLE.
- In IDLE: ignored. kill_i has priority over valid_i.

Reset mid-operation:
- Immediate return to reset values. No stale valid_o after reset release.

Test Plan:
1. NumMul=2, M16x16, signed, add_mode=01, sub=01, a=0x0003_0002, b=0x0005_0004 -> result_o=0x0000_0007, valid_o exactly 2 cycles after accept, ov_o=0.
2. NumMul=1, M32x32, signed, high_i=1, a=b=0x8000_0000 -> result_o=0x4000_0000 after 5 cycles. NumMul=4 gives the same value after 2 cycles.
3. M8x8, unsigned, add_mode=10, a=b=0xFFFF_FFFF, c=0 -> result_o=0x0003_F804.
4. M16x16, signed, add_mode=10, sat_i=1, a=b=0x0000_0001, c=0x7FFF_FFFF -> result_o=0x7FFF_FFFF, ov_o=1. Same stimulus with sat_i=0 -> 0x8000_0000, ov_o=0.
5. M32x16, signed, bsel_i=0, round_i=1, a=0x0001_8000, b=0x0000_0001 -> result_o=0x0000_0002. Same with round_i=0 -> 0x0000_0001.
6. Hold ready_i=0 for 3 cycles in DONE -> result_o stable and ready_o=0. Assert kill_i during MUL of a second op -> no valid_o, IDLE next cycle. Assert rst_i mid-MUL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ibex_mult_pext_seq.sv
// ibex_mult_pext_seq
// Multi-cycle SIMD multiply/MAC sequencer for the P-extension datapath.
// One op is accepted per handshake. Its partial products are spread over
// NumMul 17x17 signed multiplier slots per cycle and summed into a 66-bit
// accumulator. A single FIN cycle then combines, accumulates, rounds and
// saturates the sum, and the result is held until the consumer takes it.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i / ready_o   op request / op accepted (ready_o only in IDLE)
//   kill_i              abort the op in flight (MUL, FIN or DONE)
//   mode_i              multiplier mode (M8x8, M16x16, M32x16, M32x32)
//   add_mode_i, sub_i   combine/accumulate enables and their subtract selects
//   signed_a_i/_b_i     operand element signedness
//   swap_i, bsel_i      M16x16 cross pairing, M32x16 b half select
//   high_i, round_i     M32x32 upper word, round-half-up on the dropped MSB
//   sat_i               32-bit signed saturation of the final result
//   op_a_i, op_b_i      multiplicands
//   op_c_i              accumulator operand (rd)
//   valid_o / ready_i   result valid / consumer accepts the result
//   result_o, ov_o      registered result and saturation flag
//   busy_o              sequencer not idle

package ibex_pkg_pext;
  typedef enum logic [1:0] {
    MULT_M8X8   = 2'd0,
    MULT_M16X16 = 2'd1,
    MULT_M32X16 = 2'd2,
    MULT_M32X32 = 2'd3
  } mult_pext_mode_e;
endpackage

module ibex_mult_pext_seq
  import ibex_pkg_pext::*;
#(
  parameter int unsigned NumMul = 2,
  parameter bit          SatEn  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            kill_i,
  input  mult_pext_mode_e mode_i,
  input  logic [1:0]      add_mode_i,
  input  logic [1:0]      sub_i,
  input  logic            signed_a_i,
  input  logic            signed_b_i,
  input  logic            swap_i,
  input  logic            bsel_i,
  input  logic            high_i,
  input  logic            round_i,
  input  logic            sat_i,
  input  logic [31:0]     op_a_i,
  input  logic [31:0]     op_b_i,
  input  logic [31:0]     op_c_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     result_o,
  output logic            ov_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0]         NUM_MUL = 4'(NumMul);
  localparam logic signed [65:0] SAT_MAX = {34'd0, 32'h7FFF_FFFF};
  localparam logic signed [65:0] SAT_MIN = {{34{1'b1}}, 32'h8000_0000};

  // Extend an 8-bit element to a 17-bit multiplier input.
  function automatic logic [16:0] ext8(input logic [7:0] v, input logic s);
    return {{9{s & v[7]}}, v};
  endfunction

  // Extend a 16-bit half to a 17-bit multiplier input.
  function automatic logic [16:0] ext16(input logic [15:0] v, input logic s);
    return {s & v[15], v};
  endfunction

  // One partial product, already shifted into its accumulator position.
  // For M16x16 the combine/subtract choice is folded in here, so the
  // accumulator directly holds p0, p1+p0 or p1-p0.
  function automatic logic signed [65:0] slot_term(
    input logic [1:0]      k,
    input mult_pext_mode_e mode,
    input logic [31:0]     a,
    input logic [31:0]     b,
    input logic            sa,
    input logic            sb,
    input logic            swap,
    input logic            bsel,
    input logic            comb,
    input logic            neg
  );
    logic [16:0]        x;
    logic [16:0]        y;
    logic [5:0]         sh;
    logic signed [33:0] p;
    logic signed [65:0] t;
    x  = 17'd0;
    y  = 17'd0;
    sh = 6'd0;
    case (mode)
      MULT_M8X8: begin
        x = ext8(a[{k, 3'b000} +: 8], sa);
        y = ext8(b[{k, 3'b000} +: 8], sb);
      end
      MULT_M16X16: begin
        x = k[0] ? ext16(a[31:16], sa) : ext16(a[15:0], sa);
        y = (k[0] ^ swap) ? ext16(b[31:16], sb) : ext16(b[15:0], sb);
      end
      MULT_M32X16: begin
        x  = k[0] ? ext16(a[31:16], sa) : ext16(a[15:0], 1'b0);
        y  = bsel ? ext16(b[31:16], sb) : ext16(b[15:0], sb);
        sh = k[0] ? 6'd16 : 6'd0;
      end
      MULT_M32X32: begin
        // slot order lo*lo, hi*lo, lo*hi, hi*hi -> shift (k0 + k1) * 16
        x  = k[0] ? ext16(a[31:16], sa) : ext16(a[15:0], 1'b0);
        y  = k[1] ? ext16(b[31:16], sb) : ext16(b[15:0], 1'b0);
        sh = {k[1] & k[0], k[1] ^ k[0], 4'd0};
      end
      default: begin
        x = 17'd0;
      end
    endcase
    p = $signed(x) * $signed(y);
    t = {{32{p[33]}}, p};
    t = t <<< sh;
    if (mode == MULT_M16X16) begin
      if (!k[0] && comb && neg) begin
        t = -t;
      end else if (k[0] && !comb) begin
        t = 66'sd0;
      end else begin
        t = t;
      end
    end else begin
      t = t;
    end
    return t;
  endfunction

  state_e             state_r, state_d;
  mult_pext_mode_e    mode_r;
  logic [1:0]         add_mode_r, sub_r;
  logic               signed_a_r, signed_b_r, swap_r, bsel_r, high_r, round_r, sat_r;
  logic [31:0]        a_r, b_r, c_r;
  logic [2:0]         cnt_r;
  logic signed [65:0] acc_r;

  logic               accept_s, last_step_s;
  logic [2:0]         slots_s, slot_s;
  logic [3:0]         cnt_sum_s;
  logic signed [65:0] step_sum_s, fin_r_s, fin_acc_s, c_ext_s;
  logic [31:0]        fin_res_s;
  logic               fin_ov_s;

  assign accept_s    = (state_r == IDLE) && valid_i && !kill_i;
  assign slots_s     = ((mode_r == MULT_M8X8) || (mode_r == MULT_M32X32)) ? 3'd4 : 3'd2;
  assign cnt_sum_s   = {1'b0, cnt_r} + NUM_MUL;
  assign last_step_s = cnt_sum_s >= {1'b0, slots_s};

  assign ready_o = (state_r == IDLE);
  assign busy_o  = (state_r != IDLE);
  assign valid_o = (state_r == DONE);

  // Partial products issued this cycle; slots past the mode's count are skipped.
  always_comb begin
    step_sum_s = 66'sd0;
    slot_s     = 3'd0;
    for (int j = 0; j < NumMul; j++) begin
      slot_s = cnt_r + 3'(j);
      if (slot_s < slots_s) begin
        step_sum_s = step_sum_s + slot_term(slot_s[1:0], mode_r, a_r, b_r, signed_a_r,
                                            signed_b_r, swap_r, bsel_r, add_mode_r[0],
                                            sub_r[0]);
      end else begin
        step_sum_s = step_sum_s;
      end
    end
  end

  // Final combine, accumulate, round and saturate from the summed products.
  always_comb begin
    fin_r_s   = acc_r;
    fin_acc_s = 66'sd0;
    fin_res_s = 32'd0;
    fin_ov_s  = 1'b0;
    c_ext_s   = $signed({{34{c_r[31]}}, c_r});
    case (mode_r)
      MULT_M32X16: begin
        fin_r_s = (acc_r >>> 16) + $signed({65'd0, round_r & acc_r[15]});
      end
      MULT_M32X32: begin
        if (high_r) begin
          fin_r_s = (acc_r >>> 32) + $signed({65'd0, round_r & acc_r[31]});
        end else begin
          fin_r_s = $signed({{34{acc_r[31]}}, acc_r[31:0]});
        end
      end
      default: begin
        fin_r_s = acc_r;
      end
    endcase
    if (add_mode_r[1]) begin
      fin_acc_s = sub_r[1] ? (c_ext_s - fin_r_s) : (c_ext_s + fin_r_s);
    end else begin
      fin_acc_s = fin_r_s;
    end
    if (SatEn && sat_r) begin
      if (fin_acc_s > SAT_MAX) begin
        fin_res_s = 32'h7FFF_FFFF;
        fin_ov_s  = 1'b1;
      end else if (fin_acc_s < SAT_MIN) begin
        fin_res_s = 32'h8000_0000;
        fin_ov_s  = 1'b1;
      end else begin
        fin_res_s = fin_acc_s[31:0];
      end
    end else begin
      fin_res_s = fin_acc_s[31:0];
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Next-state logic; kill_i aborts any non-idle state.
  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_d = MUL;
        else          state_d = IDLE;
      end
      MUL: begin
        if (kill_i)           state_d = IDLE;
        else if (last_step_s) state_d = FIN;
        else                  state_d = MUL;
      end
      FIN: begin
        if (kill_i) state_d = IDLE;
        else        state_d = DONE;
      end
      DONE: begin
        if (kill_i || ready_i) state_d = IDLE;
        else                   state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, product accumulation and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_r     <= MULT_M8X8;
      add_mode_r <= 2'd0;
      sub_r      <= 2'd0;
      signed_a_r <= 1'b0;
      signed_b_r <= 1'b0;
      swap_r     <= 1'b0;
      bsel_r     <= 1'b0;
      high_r     <= 1'b0;
      round_r    <= 1'b0;
      sat_r      <= 1'b0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      c_r        <= 32'd0;
      cnt_r      <= 3'd0;
      acc_r      <= 66'sd0;
      result_o   <= 32'd0;
      ov_o       <= 1'b0;
    end else begin
      if (accept_s) begin
        mode_r     <= mode_i;
        add_mode_r <= add_mode_i;
        sub_r      <= sub_i;
        signed_a_r <= signed_a_i;
        signed_b_r <= signed_b_i;
        swap_r     <= swap_i;
        bsel_r     <= bsel_i;
        high_r     <= high_i;
        round_r    <= round_i;
        sat_r      <= sat_i;
        a_r        <= op_a_i;
        b_r        <= op_b_i;
        c_r        <= op_c_i;
        cnt_r      <= 3'd0;
        acc_r      <= 66'sd0;
      end else if ((state_r == MUL) && !kill_i) begin
        cnt_r <= cnt_sum_s[2:0];
        acc_r <= acc_r + step_sum_s;
      end
      if ((state_r == FIN) && !kill_i) begin
        result_o <= fin_res_s;
        ov_o     <= fin_ov_s;
      end
    end
  end

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
module tb_ibex_mult_pext_seq;
  import ibex_pkg_pext::*;

  typedef struct {
    mult_pext_mode_e mode;
    logic [1:0]      add;
    logic [1:0]      sub;
    logic            sa, sb, swap, bsel, high, rnd, sat;
    logic [31:0]     a, b, c;
  } op_t;

  typedef struct {
    logic [31:0] res;
    logic        ov;
  } exp_t;

  localparam logic signed [65:0] MAXV = {34'd0, 32'h7FFF_FFFF};
  localparam logic signed [65:0] MINV = {{34{1'b1}}, 32'h8000_0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            valid_i = 1'b0, kill_i = 1'b0, ready_i = 1'b1;
  mult_pext_mode_e mode = MULT_M8X8;
  logic [1:0]      add_mode = 2'd0, sub = 2'd0;
  logic            signed_a = 1'b0, signed_b = 1'b0, swap = 1'b0, bsel = 1'b0;
  logic            high = 1'b0, rnd = 1'b0, sat = 1'b0;
  logic [31:0]     op_a = 32'd0, op_b = 32'd0, op_c = 32'd0;

  logic [2:0]  ready_v, valid_v, ov_v, busy_v;
  logic [31:0] res_v [3];

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  ibex_mult_pext_seq #(.NumMul(1), .SatEn(1'b1)) u_dut_n1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_v[0]), .kill_i(kill_i),
    .mode_i(mode), .add_mode_i(add_mode), .sub_i(sub), .signed_a_i(signed_a),
    .signed_b_i(signed_b), .swap_i(swap), .bsel_i(bsel), .high_i(high), .round_i(rnd),
    .sat_i(sat), .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .valid_o(valid_v[0]),
    .ready_i(ready_i), .result_o(res_v[0]), .ov_o(ov_v[0]), .busy_o(busy_v[0]));

  ibex_mult_pext_seq #(.NumMul(2), .SatEn(1'b1)) u_dut_n2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_v[1]), .kill_i(kill_i),
    .mode_i(mode), .add_mode_i(add_mode), .sub_i(sub), .signed_a_i(signed_a),
    .signed_b_i(signed_b), .swap_i(swap), .bsel_i(bsel), .high_i(high), .round_i(rnd),
    .sat_i(sat), .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .valid_o(valid_v[1]),
    .ready_i(ready_i), .result_o(res_v[1]), .ov_o(ov_v[1]), .busy_o(busy_v[1]));

  ibex_mult_pext_seq #(.NumMul(4), .SatEn(1'b1)) u_dut_n4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_v[2]), .kill_i(kill_i),
    .mode_i(mode), .add_mode_i(add_mode), .sub_i(sub), .signed_a_i(signed_a),
    .signed_b_i(signed_b), .swap_i(swap), .bsel_i(bsel), .high_i(high), .round_i(rnd),
    .sat_i(sat), .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .valid_o(valid_v[2]),
    .ready_i(ready_i), .result_o(res_v[2]), .ov_o(ov_v[2]), .busy_o(busy_v[2]));

  // Single comparison point: counts and reports.
  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk_op(input mult_pext_mode_e m, input logic [1:0] ad,
                                input logic [1:0] sb_, input logic s_a, input logic s_b,
                                input logic sw, input logic bs, input logic hi,
                                input logic rn, input logic st, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] c);
    op_t o;
    o.mode = m; o.add = ad; o.sub = sb_; o.sa = s_a; o.sb = s_b; o.swap = sw;
    o.bsel = bs; o.high = hi; o.rnd = rn; o.sat = st; o.a = a; o.b = b; o.c = c;
    return o;
  endfunction

  function automatic logic signed [65:0] e8(input logic [7:0] v, input logic s);
    return {{58{s & v[7]}}, v};
  endfunction

  function automatic logic signed [65:0] e16(input logic [15:0] v, input logic s);
    return {{50{s & v[15]}}, v};
  endfunction

  // Reference model working on whole operands rather than 17-bit slots.
  function automatic exp_t ref_model(input op_t o);
    logic signed [65:0] ae, be, he, p, p0, p1, r, c;
    logic [15:0]        bl0, bl1;
    exp_t               e;
    ae = o.sa ? {{34{o.a[31]}}, o.a} : {34'd0, o.a};
    be = o.sb ? {{34{o.b[31]}}, o.b} : {34'd0, o.b};
    r  = 66'sd0;
    case (o.mode)
      MULT_M8X8: begin
        for (int i = 0; i < 4; i++) r = r + e8(o.a[8*i +: 8], o.sa) * e8(o.b[8*i +: 8], o.sb);
      end
      MULT_M16X16: begin
        bl0 = o.swap ? o.b[31:16] : o.b[15:0];
        bl1 = o.swap ? o.b[15:0] : o.b[31:16];
        p0  = e16(o.a[15:0], o.sa) * e16(bl0, o.sb);
        p1  = e16(o.a[31:16], o.sa) * e16(bl1, o.sb);
        if (!o.add[0])     r = p0;
        else if (o.sub[0]) r = p1 - p0;
        else               r = p1 + p0;
      end
      MULT_M32X16: begin
        he = e16(o.bsel ? o.b[31:16] : o.b[15:0], o.sb);
        p  = ae * he;
        r  = p >>> 16;
        if (o.rnd && p[15]) r = r + 66'sd1;
      end
      default: begin
        p = ae * be;
        if (o.high) begin
          r = p >>> 32;
          if (o.rnd && p[31]) r = r + 66'sd1;
        end else begin
          r = {{34{p[31]}}, p[31:0]};
        end
      end
    endcase
    c = {{34{o.c[31]}}, o.c};
    if (o.add[1]) r = o.sub[1] ? (c - r) : (c + r);
    e.ov = 1'b0;
    e.res = r[31:0];
    if (o.sat && (r > MAXV)) begin
      e.ov = 1'b1; e.res = 32'h7FFF_FFFF;
    end else if (o.sat && (r < MINV)) begin
      e.ov = 1'b1; e.res = 32'h8000_0000;
    end
    return e;
  endfunction

  function automatic int lat_of(input mult_pext_mode_e m, input int n);
    int s;
    s = ((m == MULT_M8X8) || (m == MULT_M32X32)) ? 4 : 2;
    return (s + n - 1) / n + 1;
  endfunction

  task automatic apply(input op_t o);
    mode = o.mode; add_mode = o.add; sub = o.sub; signed_a = o.sa; signed_b = o.sb;
    swap = o.swap; bsel = o.bsel; high = o.high; rnd = o.rnd; sat = o.sat;
    op_a = o.a; op_b = o.b; op_c = o.c;
  endtask

  // Issue one op to all three sequencers and score each result and latency.
  task automatic run_op(input string tag, input op_t o, input exp_t e);
    logic [2:0] seen;
    exp_t       x;
    int         nm [3];
    nm[0] = 1; nm[1] = 2; nm[2] = 4;
    exp_q.push_back(e);
    @(negedge clk);
    apply(o);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    seen = 3'b000;
    x = exp_q.pop_front();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && valid_v[d]) begin
          seen[d] = 1'b1;
          check_value({tag, "_res"}, res_v[d], x.res);
          check_value({tag, "_ov"}, 32'(ov_v[d]), 32'(x.ov));
          check_value({tag, "_lat"}, 32'(k), 32'(lat_of(o.mode, nm[d])));
        end
      end
      if (seen == 3'b111) break;
    end
    for (int d = 0; d < 3; d++) begin
      if (!seen[d]) check_value({tag, "_timeout"}, 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    op_t  o;
    exp_t e;
    logic [31:0] held;
    logic [2:0]  any_valid;
    logic        found;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_value("rst_ready", 32'(ready_v), 32'h7);
    check_value("rst_valid", 32'(valid_v), 32'h0);
    check_value("rst_busy", 32'(busy_v), 32'h0);
    check_value("rst_ov", 32'(ov_v), 32'h0);
    check_value("rst_res", res_v[1], 32'h0);

    o = mk_op(MULT_M16X16, 2'b01, 2'b01, 1, 1, 0, 0, 0, 0, 0, 32'h0003_0002, 32'h0005_0004, 32'h0);
    e.res = 32'h0000_0007; e.ov = 1'b0; run_op("t1_m16", o, e);
    o = mk_op(MULT_M32X32, 2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 32'h8000_0000, 32'h8000_0000, 32'h0);
    e.res = 32'h4000_0000; e.ov = 1'b0; run_op("t2_m32hi", o, e);
    o = mk_op(MULT_M8X8, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    e.res = 32'h0003_F804; e.ov = 1'b0; run_op("t3_m8", o, e);
    o = mk_op(MULT_M16X16, 2'b10, 2'b00, 1, 1, 0, 0, 0, 0, 1, 32'h1, 32'h1, 32'h7FFF_FFFF);
    e.res = 32'h7FFF_FFFF; e.ov = 1'b1; run_op("t4_sat", o, e);
    o.sat = 1'b0;
    e.res = 32'h8000_0000; e.ov = 1'b0; run_op("t4_wrap", o, e);
    o = mk_op(MULT_M32X16, 2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 32'h0001_8000, 32'h1, 32'h0);
    e.res = 32'h0000_0002; e.ov = 1'b0; run_op("t5_rnd", o, e);
    o.rnd = 1'b0;
    e.res = 32'h0000_0001; e.ov = 1'b0; run_op("t5_nornd", o, e);

    for (int i = 0; i < 24; i++) begin
      o = mk_op(mult_pext_mode_e'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom);
      run_op("rand", o, ref_model(o));
    end

    // Result must hold while the consumer stalls.
    o = mk_op(MULT_M16X16, 2'b01, 2'b01, 1, 1, 0, 0, 0, 0, 0, 32'h0003_0002, 32'h0005_0004, 32'h0);
    @(negedge clk);
    ready_i = 1'b0;
    apply(o);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (valid_v[1]) begin
        found = 1'b1;
        break;
      end
    end
    check_value("hold_seen", 32'(found), 32'h1);
    held = res_v[1];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_value("hold_res", res_v[1], 32'h0000_0007);
      check_value("hold_stable", res_v[1], held);
      check_value("hold_valid", 32'(valid_v[1]), 32'h1);
      check_value("hold_ready", 32'(ready_v[1]), 32'h0);
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check_value("hold_release", 32'(ready_v), 32'h7);

    // Kill during MUL: no result, idle on the next cycle.
    o = mk_op(MULT_M32X32, 2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 32'h8000_0000, 32'h8000_0000, 32'h0);
    @(negedge clk);
    apply(o);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    check_value("kill_inmul", 32'(busy_v), 32'h7);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    check_value("kill_busy", 32'(busy_v), 32'h0);
    check_value("kill_ready", 32'(ready_v), 32'h7);
    any_valid = 3'b000;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 any_valid = any_valid | valid_v;
    end
    check_value("kill_novalid", 32'(any_valid), 32'h0);

    // Reset in the middle of an op.
    @(negedge clk);
    apply(o);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_value("mrst_valid", 32'(valid_v), 32'h0);
    check_value("mrst_ready", 32'(ready_v), 32'h7);
    check_value("mrst_busy", 32'(busy_v), 32'h0);
    check_value("mrst_ov", 32'(ov_v), 32'h0);
    for (int d = 0; d < 3; d++) check_value("mrst_res", res_v[d], 32'h0);
    #3 rst = 1'b0;
    any_valid = 3'b000;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 any_valid = any_valid | valid_v;
    end
    check_value("mrst_novalid", 32'(any_valid), 32'h0);

    o = mk_op(MULT_M16X16, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 0, 32'h0003_0002, 32'h0005_0004, 32'h0);
    e.res = 32'h0000_0016; e.ov = 1'b0; run_op("post_rst_swap", o, e);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
